clk_div_bank: RTL and testbench
===============================

CLK_DIV_BANK -- requirements
Module: clk_div_bank

Interface
REQ-001 Parameter NCH, default 4, number of independent output clock channels (1..16).
REQ-002 Parameter CW, default 8, width of divide-ratio field and per-channel counter.
REQ-003 clk  input  1  reference clock; all state on rising edge.
REQ-004 w_reset  input  1  reset, synchronous, active-high.
REQ-005 cfg_we  input  1  config write strobe, one cycle per write.
REQ-006 cfg_ch  input  max(1,$clog2(NCH))  target channel index for cfg_we.
REQ-007 cfg_div  input  CW  requested divide ratio N.
REQ-008 cfg_en  input  1  requested channel run enable.
REQ-009 sync  input  1  phase-align pulse for all running channels.
REQ-010 clk_out  output  NCH  divided clocks, bit i = channel i, register-driven.
REQ-011 tick  output  NCH  one-cycle pulse coincident with each rising edge of clk_out[i].
REQ-012 pend  output  NCH  bit i high while channel i holds an unapplied config.

Function
REQ-013 Each channel SHALL hold active div/en, pending div/en, a pend flag, and a CW-bit counter cnt.
REQ-014 Effective ratio SHALL be max(N,2); N=0 or 1 SHALL clamp to 2.
REQ-015 Channel states SHALL be STOPPED and RUN; no other states.
REQ-016 RUN: cnt SHALL count 0..N-1 and wrap to 0; clk_out[i] = 1 when cnt < (N+1)/2 (integer), else 0.
REQ-017 Odd N SHALL yield high time (N+1)/2 and low time (N-1)/2 cycles; even N exactly 50%.
REQ-018 tick[i] SHALL be 1 exactly in cycles where channel is RUN and cnt==0.
REQ-019 cfg_we with index >= NCH SHALL be ignored.
REQ-020 cfg_we SHALL load pending div/en and set pend[i] on the next edge; a second write before apply SHALL overwrite (last wins).
REQ-021 RUN channel SHALL apply pending only on the edge where cnt==N-1 (period boundary), clearing pend; no shortened or stretched pulse allowed.
REQ-022 Applied en=0 SHALL move channel to STOPPED with cnt=0, clk_out=0, after completing the full current period.
REQ-023 STOPPED channel with pend set SHALL apply on the next edge; if en=1, enter RUN with cnt=0 (clk_out=1, tick=1).
REQ-024 Latency: cfg_we sampled at edge E on a STOPPED channel -> clk_out high and tick after edge E+2.
REQ-025 sync sampled high SHALL force cnt=0 on all RUN channels at that edge; pending configs SHALL then apply at that edge as if at boundary.
REQ-026 cfg_we and boundary on same channel same edge: active config SHALL apply old pending (if any); new write becomes pending.
REQ-027 sync and cfg_we same edge: sync takes effect; write lands in pending per REQ-020.

Reset
REQ-028 While w_reset is high at an edge: all channels STOPPED, cnt=0, active and pending div=2, en=0, pend=0, clk_out=0, tick=0.
REQ-029 Reset asserted mid-period SHALL terminate the period immediately; no completion guarantee.
REQ-030 First cfg_we SHALL be accepted on the first edge with w_reset low.

Structure
REQ-031 Shared package clk_div_pkg SHALL hold DIV_MIN=2, default NCH/CW, and channel-state enumeration (STOPPED, RUN).
REQ-032 Per-channel logic SHALL be sub-module clk_div_chan, instanced NCH times by generate; top holds config decode only.
REQ-033 clk_out and tick SHALL be direct flop outputs; no combinational path from inputs to outputs.

Verification
REQ-034 Reset, write ch0 N=4 en=1 -> clk_out[0] pattern 1100 repeating, tick every 4 cycles, first high after E+2.
REQ-035 ch1 N=5 -> high 3, low 2 cycles; N=0 and N=1 -> both behave as N=2 (1010...).
REQ-036 ch0 running N=4, write N=6 at cnt=1 -> current period completes as 1100, then 111000; pend[0] high until boundary.
REQ-037 ch2 N=3 running, write en=0 -> finishes current period, then clk_out[2]=0, tick never again; re-enable restarts cnt=0.
REQ-038 ch0 N=4 and ch1 N=6 running, pulse sync -> both tick on the following cycle, then coincident every 12 cycles.
REQ-039 Assert w_reset mid-period with pend set -> next cycle all outputs 0, pend=0; cfg_ch=NCH write -> no change.

Source files
------------

// File: rtl/clk_div_pkg.sv
// Shared constants and channel state type for the divided-clock bank.
package clk_div_pkg;

    localparam int unsigned DIV_MIN = 2;
    localparam int unsigned DEF_NCH = 4;
    localparam int unsigned DEF_CW  = 8;

    typedef enum logic {
        STOPPED = 1'b0,
        RUN     = 1'b1
    } chan_state_e;

endpackage

// File: rtl/clk_div_chan.sv
// One divider channel: active/pending config, period counter, registered outputs.
module clk_div_chan
    import clk_div_pkg::*;
#(
    parameter int unsigned CW = DEF_CW
) (
    input  logic          clk,
    input  logic          w_reset,
    input  logic          we_i,
    input  logic [CW-1:0] div_i,
    input  logic          en_i,
    input  logic          sync_i,
    output logic          clk_out_o,
    output logic          tick_o,
    output logic          pend_o
);

    localparam logic [CW-1:0] DIV_MIN_W = CW'(DIV_MIN);
    localparam logic [CW-1:0] ONE_W     = CW'(1);

    chan_state_e   state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [CW-1:0] act_div_q, act_div_d;
    logic          act_en_q, act_en_d;
    logic [CW-1:0] pend_div_q, pend_div_d;
    logic          pend_en_q, pend_en_d;
    logic          pend_q, pend_d;
    logic          clk_out_q, clk_out_d;
    logic          tick_q, tick_d;

    logic [CW:0]   half_w;
    logic          last_w;
    logic          apply_w;

    // High phase length (N+1)/2, one bit wider so N = 2^CW-1 cannot overflow.
    assign half_w = ({1'b0, act_div_q} + (CW+1)'(1)) >> 1;
    assign last_w = (cnt_q == (act_div_q - ONE_W));

    // Next-state: count, period-boundary/sync apply, pending capture, output decode.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        act_div_d  = act_div_q;
        act_en_d   = act_en_q;
        pend_div_d = pend_div_q;
        pend_en_d  = pend_en_q;
        pend_d     = pend_q;
        apply_w    = 1'b0;

        // Outputs are decoded from the current state and registered, so they
        // trail the counter by one cycle and never see inputs combinationally.
        clk_out_d = (state_q == RUN) && ({1'b0, cnt_q} < half_w);
        tick_d    = (state_q == RUN) && (cnt_q == '0);

        case (state_q)
            RUN: begin
                if (sync_i || last_w) begin
                    cnt_d   = '0;
                    apply_w = pend_q;
                end else begin
                    cnt_d = cnt_q + ONE_W;
                end
            end
            default: begin
                cnt_d   = '0;
                apply_w = pend_q;
            end
        endcase

        // Apply uses the pending value held before this edge; a write on the
        // same edge then refills pending below.
        if (apply_w) begin
            act_div_d = pend_div_q;
            act_en_d  = pend_en_q;
            pend_d    = 1'b0;
            cnt_d     = '0;
            state_d   = act_en_d ? RUN : STOPPED;
        end

        if (we_i) begin
            pend_div_d = (div_i < DIV_MIN_W) ? DIV_MIN_W : div_i;
            pend_en_d  = en_i;
            pend_d     = 1'b1;
        end
    end

    // State and output registers with synchronous active-high reset.
    always_ff @(posedge clk) begin
        if (w_reset) begin
            state_q    <= STOPPED;
            cnt_q      <= '0;
            act_div_q  <= DIV_MIN_W;
            act_en_q   <= 1'b0;
            pend_div_q <= DIV_MIN_W;
            pend_en_q  <= 1'b0;
            pend_q     <= 1'b0;
            clk_out_q  <= 1'b0;
            tick_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            act_div_q  <= act_div_d;
            act_en_q   <= act_en_d;
            pend_div_q <= pend_div_d;
            pend_en_q  <= pend_en_d;
            pend_q     <= pend_d;
            clk_out_q  <= clk_out_d;
            tick_q     <= tick_d;
        end
    end

    assign clk_out_o = clk_out_q;
    assign tick_o    = tick_q;
    assign pend_o    = pend_q;

endmodule

// File: rtl/clk_div_bank.sv
// Bank of NCH independent clock dividers; this level only decodes config writes.
module clk_div_bank
    import clk_div_pkg::*;
#(
    parameter  int unsigned NCH = DEF_NCH,
    parameter  int unsigned CW  = DEF_CW,
    localparam int unsigned CHW = (NCH > 1) ? $clog2(NCH) : 1
) (
    input  logic           clk,
    input  logic           w_reset,
    input  logic           cfg_we,
    input  logic [CHW-1:0] cfg_ch,
    input  logic [CW-1:0]  cfg_div,
    input  logic           cfg_en,
    input  logic           sync,
    output logic [NCH-1:0] clk_out,
    output logic [NCH-1:0] tick,
    output logic [NCH-1:0] pend
);

    // Indices >= NCH match no channel, so such writes fall away here.
    for (genvar i = 0; i < NCH; i++) begin : g_chan
        logic we_w;
        assign we_w = cfg_we && (cfg_ch == CHW'(i));

        clk_div_chan #(
            .CW (CW)
        ) u_chan (
            .clk       (clk),
            .w_reset   (w_reset),
            .we_i      (we_w),
            .div_i     (cfg_div),
            .en_i      (cfg_en),
            .sync_i    (sync),
            .clk_out_o (clk_out[i]),
            .tick_o    (tick[i]),
            .pend_o    (pend[i])
        );
    end

endmodule

// File: tb/tb_clk_div_bank.sv
// Bench for clk_div_bank: directed patterns plus randomized traffic vs a behavioural model.
module tb_clk_div_bank;

    localparam int NCH = 3;
    localparam int CW  = 8;
    localparam int CHW = 2;

    logic           clk = 1'b0;
    logic           w_reset = 1'b1;
    logic           cfg_we = 1'b0;
    logic [CHW-1:0] cfg_ch = '0;
    logic [CW-1:0]  cfg_div = '0;
    logic           cfg_en = 1'b0;
    logic           sync = 1'b0;
    logic [NCH-1:0] clk_out, tick, pend;

    clk_div_bank #(
        .NCH (NCH),
        .CW  (CW)
    ) dut (
        .clk     (clk),
        .w_reset (w_reset),
        .cfg_we  (cfg_we),
        .cfg_ch  (cfg_ch),
        .cfg_div (cfg_div),
        .cfg_en  (cfg_en),
        .sync    (sync),
        .clk_out (clk_out),
        .tick    (tick),
        .pend    (pend)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    bit chk_on = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: each channel is "running with ratio N at position p
    // within its period"; outputs seen in a cycle describe the position held
    // during the previous cycle.
    int             m_run [NCH];
    int             m_div [NCH];
    int             m_pos [NCH];
    int             m_pend[NCH];
    int             m_pdiv[NCH];
    int             m_pen [NCH];
    logic [NCH-1:0] exp_clk, exp_tick, exp_pend;

    always @(posedge clk) begin
        for (int i = 0; i < NCH; i++) begin
            if (w_reset) begin
                m_run[i] = 0; m_div[i] = 2; m_pos[i] = 0;
                m_pend[i] = 0; m_pdiv[i] = 2; m_pen[i] = 0;
                exp_clk[i] = 1'b0; exp_tick[i] = 1'b0;
            end else begin
                bit boundary;
                exp_clk[i]  = (m_run[i] != 0) && (m_pos[i] < (m_div[i] + 1) / 2);
                exp_tick[i] = (m_run[i] != 0) && (m_pos[i] == 0);
                boundary = (m_run[i] != 0) && (sync || m_pos[i] == m_div[i] - 1);
                if (m_run[i] != 0) m_pos[i] = boundary ? 0 : m_pos[i] + 1;
                if (m_pend[i] != 0 && (m_run[i] == 0 || boundary)) begin
                    m_div[i] = m_pdiv[i]; m_run[i] = m_pen[i];
                    m_pos[i] = 0; m_pend[i] = 0;
                end
                if (cfg_we && int'(cfg_ch) == i) begin
                    m_pdiv[i] = (int'(cfg_div) < 2) ? 2 : int'(cfg_div);
                    m_pen[i]  = int'(cfg_en);
                    m_pend[i] = 1;
                end
            end
            exp_pend[i] = (m_pend[i] != 0);
        end
    end

    // Every-cycle comparison against the model.
    always @(negedge clk) begin
        if (chk_on) begin
            chk("model_clk_out", 32'(clk_out), 32'(exp_clk));
            chk("model_tick",    32'(tick),    32'(exp_tick));
            chk("model_pend",    32'(pend),    32'(exp_pend));
        end
    end

    task automatic do_write(input int ch, input int div, input bit en);
        cfg_ch  = CHW'(ch);
        cfg_div = CW'(div);
        cfg_en  = en;
        cfg_we  = 1'b1;
        @(negedge clk);
        cfg_we  = 1'b0;
    endtask

    // Collects n samples (current negedge first), first sample ends up MSB.
    task automatic sample(input int ch, input int n, output logic [31:0] c, output logic [31:0] t);
        c = '0;
        t = '0;
        for (int k = 0; k < n; k++) begin
            if (k > 0) @(negedge clk);
            c = {c[30:0], clk_out[ch]};
            t = {t[30:0], tick[ch]};
        end
    endtask

    task automatic wait_idle(input string name);
        for (int k = 0; k < 300 && pend != '0; k++) @(negedge clk);
        chk(name, 32'(pend), 32'd0);
    endtask

    initial begin
        logic [31:0] c, t;
        @(negedge clk);
        chk_on = 1'b1;
        @(negedge clk);
        chk("reset_state", {clk_out, tick, pend}, 32'd0);
        w_reset = 1'b0;

        // N=4 from stopped: high after E+2, pattern 1100, tick every 4.
        do_write(0, 4, 1);
        sample(0, 10, c, t);
        chk("n4_clk",  c, 32'b0011001100);
        chk("n4_tick", t, 32'b0010001000);

        // N=5: high 3, low 2.
        do_write(1, 5, 1);
        sample(1, 10, c, t);
        chk("n5_clk",  c, 32'b0011100111);
        chk("n5_tick", t, 32'b0010000100);

        // N=1 clamps to 2.
        do_write(2, 1, 1);
        sample(2, 10, c, t);
        chk("n1_clk", c, 32'b0010101010);

        // Stop, then N=0 also clamps to 2.
        do_write(2, 0, 0);
        wait_idle("idle_stop2");
        repeat (3) @(negedge clk);
        do_write(2, 0, 1);
        sample(2, 10, c, t);
        chk("n0_clk", c, 32'b0010101010);

        // N=3 running, disable: finishes period, then silent; re-enable restarts.
        do_write(2, 3, 1);
        wait_idle("idle_n3");
        do_write(2, 3, 0);
        wait_idle("idle_dis");
        repeat (4) @(negedge clk);
        sample(2, 10, c, t);
        chk("dis_clk",  c, 32'd0);
        chk("dis_tick", t, 32'd0);
        do_write(2, 3, 1);
        sample(2, 10, c, t);
        chk("reen_clk",  c, 32'b0011011011);
        chk("reen_tick", t, 32'b0010010010);

        // ch0 N=4 and ch1 N=6 aligned by sync: coincident ticks every 12.
        do_write(1, 6, 1);
        wait_idle("idle_n6");
        repeat ($urandom_range(5, 0)) @(negedge clk);
        sync = 1'b1;
        @(negedge clk);
        sync = 1'b0;
        c = '0;
        for (int k = 0; k < 13; k++) begin
            @(negedge clk);
            c = {c[30:0], tick[0] & tick[1]};
        end
        chk("sync_coinc", c, 32'b1000000000001);

        // Ratio change mid-period: current 1100 completes, then 111000.
        sync = 1'b1;
        @(negedge clk);
        sync = 1'b0;
        do_write(0, 6, 1);
        chk("chg_pend", 32'(pend[0]), 32'd1);
        sample(0, 11, c, t);
        chk("chg_clk", c, 32'b11001110001);

        // Reset mid-period with pending config.
        do_write(1, 9, 1);
        chk("pre_rst_pend", 32'(pend[1]), 32'd1);
        w_reset = 1'b1;
        @(negedge clk);
        chk("mid_reset", {clk_out, tick, pend}, 32'd0);
        w_reset = 1'b0;

        // Out-of-range channel index is ignored.
        do_write(3, 5, 1);
        chk("bad_ch_pend", 32'(pend), 32'd0);
        repeat (3) @(negedge clk);
        chk("bad_ch_clk", 32'(clk_out), 32'd0);

        // Randomized traffic, model checks every cycle.
        for (int k = 0; k < 1500; k++) begin
            w_reset = ($urandom_range(199, 0) == 0);
            cfg_we  = ($urandom_range(3, 0) == 0);
            cfg_ch  = CHW'($urandom_range(3, 0));
            cfg_div = CW'($urandom_range(12, 0));
            cfg_en  = ($urandom_range(4, 0) != 0);
            sync    = ($urandom_range(24, 0) == 0);
            @(negedge clk);
        end
        w_reset = 1'b0;
        cfg_we  = 1'b0;
        sync    = 1'b0;
        repeat (20) @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
